// File: rtl/cle_pkg.sv
// Shared types, constants and address helper for the CLE serial-data reader.
package cle_pkg;

   typedef enum logic [2:0] {IDLE, SYNC, KEY, DATA, FINISH} state_t;

   typedef enum logic [1:0] {SETUP, STROBE, RECOVER} phase_t;

   localparam logic [1:0] CLE_WIN_HI = 2'b01;
   localparam logic [3:0] NIB_SYNC   = 4'h0;

   // Responder window address: BA13..12 select the window, BA7..4 carry the code nibble.
   function automatic logic [13:0] cle_addr(input logic [3:0] nib);
      return {CLE_WIN_HI, 4'h0, nib, 4'h0};
   endfunction

endpackage

// File: rtl/cle_bus_access.sv
// Three-cycle SETUP/STROBE/RECOVER bus access engine for the CLE responder.
module cle_bus_access
   import cle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [3:0]  nib,
   output logic [13:0] ba,
   output logic        sser_n,
   output logic        bstrobe,
   output logic        sample,
   output logic        last_cycle
);

   logic   active;
   phase_t phase;

   // Launch a new access on go (from idle or straight out of RECOVER), otherwise step the phases.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         phase  <= SETUP;
         ba     <= '0;
      end else if (go && (!active || phase == RECOVER)) begin
         active <= 1'b1;
         phase  <= SETUP;
         ba     <= cle_addr(nib);
      end else if (active) begin
         case (phase)
            SETUP:   phase <= STROBE;
            STROBE:  phase <= RECOVER;
            default: begin
               active <= 1'b0;
               phase  <= SETUP;
            end
         endcase
      end
   end

   assign sser_n     = !(active && phase != RECOVER);
   assign bstrobe    = active && phase == STROBE;
   assign sample     = active && phase == STROBE;
   assign last_cycle = active && phase == RECOVER;

endmodule

// File: rtl/cle_seq_reader.sv
// Sequencer that unlocks the CLE responder with sync and key reads, then shifts in NBITS data bits.
module cle_seq_reader
   import cle_pkg::*;
#(
   parameter int          NBITS      = 16,
   parameter int          KEY_LEN    = 4,
   parameter logic [31:0] KEY        = 32'h0000_9A5B,
   parameter logic [3:0]  DATA_NIB   = 4'h2,
   parameter int          SYNC_READS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [NBITS-1:0] result,
   output logic [13:0]      ba,
   output logic             br_w,
   output logic             sser_n,
   output logic             bstrobe,
   input  logic             sdrd,
   input  logic             sdrd_valid
);

   localparam int MAX_NK  = (NBITS > KEY_LEN) ? NBITS : KEY_LEN;
   localparam int MAX_CNT = (MAX_NK > SYNC_READS) ? MAX_NK : SYNC_READS;
   localparam int CW      = $clog2(MAX_CNT + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            err_flag;
   logic            go;
   logic [3:0]      nib;
   logic            sample;
   logic            last_cycle;
   int              phase_len;
   logic            phase_end;

   // Key nibbles go out most-significant used nibble first.
   function automatic logic [3:0] key_nib(input int idx);
      logic [31:0] shifted;
      shifted = KEY >> (4 * (KEY_LEN - 1 - idx));
      return shifted[3:0];
   endfunction

   assign br_w = 1'b1;

   cle_bus_access u_access (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .nib        (nib),
      .ba         (ba),
      .sser_n     (sser_n),
      .bstrobe    (bstrobe),
      .sample     (sample),
      .last_cycle (last_cycle)
   );

   // Number of accesses in the current phase and whether the running access is its last one.
   always_comb begin
      case (state)
         SYNC:         phase_len = SYNC_READS;
         cle_pkg::KEY: phase_len = KEY_LEN;
         default:      phase_len = NBITS;
      endcase
      phase_end = (int'(cnt) + 1 >= phase_len);
   end

   // Decide whether the next access starts back to back and which nibble it carries.
   always_comb begin
      go  = 1'b0;
      nib = NIB_SYNC;
      case (state)
         IDLE: begin
            go  = start;
            nib = (SYNC_READS > 0) ? NIB_SYNC : key_nib(0);
         end
         SYNC: begin
            go  = last_cycle && !abort;
            nib = phase_end ? key_nib(0) : NIB_SYNC;
         end
         cle_pkg::KEY: begin
            go  = last_cycle && !abort;
            nib = phase_end ? DATA_NIB : key_nib(int'(cnt) + 1);
         end
         DATA: begin
            go  = last_cycle && !abort && !phase_end;
            nib = DATA_NIB;
         end
         default: ;
      endcase
   end

   // Phase sequencing, access counting, data shifting and the registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         err_flag <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  result   <= '0;
                  err_flag <= 1'b0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= (SYNC_READS > 0) ? SYNC : cle_pkg::KEY;
               end
            end
            SYNC, cle_pkg::KEY, DATA: begin
               if (state == DATA && sample) begin
                  result <= (result << 1) | NBITS'(sdrd & sdrd_valid);
                  if (!sdrd_valid) begin
                     err_flag <= 1'b1;
                  end
               end
               if (last_cycle) begin
                  if (abort) begin
                     state <= FINISH;
                     cnt   <= '0;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end else if (phase_end) begin
                     cnt <= '0;
                     case (state)
                        SYNC:         state <= cle_pkg::KEY;
                        cle_pkg::KEY: state <= DATA;
                        default: begin
                           state <= FINISH;
                           busy  <= 1'b0;
                           done  <= !err_flag;
                           err   <= err_flag;
                        end
                     endcase
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cle_seq_reader.sv
// Randomized self-checking bench for cle_seq_reader with a transaction-level reference model.
module tb_cle_seq_reader;

   localparam int          NB   = 16;
   localparam int          KL   = 4;
   localparam int          SR   = 2;
   localparam logic [31:0] KEYV = 32'h0000_9A5B;
   localparam logic [3:0]  DNIB = 4'h2;
   localparam int          NACC = SR + KL + NB;

   logic          clk = 1'b0;
   logic          rst, start, abort, sdrd, sdrd_valid;
   logic          busy, done, err, br_w, sser_n, bstrobe;
   logic [NB-1:0] result;
   logic [13:0]   ba;

   int errors = 0;
   int checks = 0;

   int            cyc, acc_count, strobe_count, low_run, viol, done_count, finish_cyc;
   int            resp_bad, abort_acc, restart_at;
   logic [NB-1:0] resp_word, fin_result;
   logic          fin_done, fin_err, prev_sser;
   logic [13:0]   got_addr [$];

   always #5 clk = ~clk;

   cle_seq_reader #(
      .NBITS      (NB),
      .KEY_LEN    (KL),
      .KEY        (KEYV),
      .DATA_NIB   (DNIB),
      .SYNC_READS (SR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .result     (result),
      .ba         (ba),
      .br_w       (br_w),
      .sser_n     (sser_n),
      .bstrobe    (bstrobe),
      .sdrd       (sdrd),
      .sdrd_valid (sdrd_valid)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput(tag, 64'({busy, done, err, result, ba, br_w, sser_n, bstrobe}),
                  64'({3'b000, {NB{1'b0}}, 14'h0000, 3'b110}));
   endtask

   // Expected address of access k, straight from the protocol description.
   function automatic logic [13:0] model_addr(input int k);
      int nib;
      if (k < SR)           nib = 0;
      else if (k < SR + KL) nib = int'((KEYV >> (4 * (KL - 1 - (k - SR)))) & 32'hF);
      else                  nib = int'(DNIB);
      return 14'(32'h1000 + nib * 16);
   endfunction

   // One clock: observe the bus at the falling edge, act as the responder, drive host inputs.
   task automatic applyStimulus();
      int di;
      @(negedge clk);
      cyc++;
      if (!sser_n) begin
         if (prev_sser) begin
            acc_count++;
            got_addr.push_back(ba);
            low_run = 1;
            if (bstrobe) viol++;
         end else begin
            low_run++;
            if (bstrobe != (low_run == 2)) viol++;
            if (low_run > 2) viol++;
            if (ba !== got_addr[$]) viol++;
         end
         if (br_w !== 1'b1) viol++;
      end else begin
         if (!prev_sser && low_run != 2) viol++;
         if (bstrobe) viol++;
      end
      prev_sser = sser_n;
      if (done || err) begin
         done_count++;
         if (finish_cyc < 0) begin
            finish_cyc = cyc;
            fin_result = result;
            fin_done   = done;
            fin_err    = err;
            if (busy) viol++;
         end
      end else if (finish_cyc < 0 && busy !== 1'b1) begin
         viol++;
      end
      if (finish_cyc >= 0 && cyc > finish_cyc && (!sser_n || busy)) viol++;
      sdrd       = 1'($urandom);
      sdrd_valid = 1'($urandom);
      if (bstrobe) begin
         strobe_count++;
         di = strobe_count - 1 - SR - KL;
         if (di >= 0) begin
            sdrd_valid = (di != resp_bad);
            sdrd       = (di != resp_bad) ? resp_word[NB-1-di] : 1'b1;
         end
      end
      start = (cyc == restart_at);
      abort = (finish_cyc < 0) && (acc_count - 1 == abort_acc);
   endtask

   task automatic beginRun(input logic [NB-1:0] word, input int bad, input int ab_acc, input int re_at);
      resp_word    = word;
      resp_bad     = bad;
      abort_acc    = ab_acc;
      restart_at   = re_at;
      cyc          = 0;
      acc_count    = 0;
      strobe_count = 0;
      low_run      = 0;
      viol         = 0;
      done_count   = 0;
      finish_cyc   = -1;
      prev_sser    = 1'b1;
      got_addr.delete();
      @(negedge clk);
      start = 1'b1;
      abort = (ab_acc == 0);
   endtask

   task automatic runSeq(input logic [NB-1:0] word, input int bad, input int ab_acc,
                         input int re_at, input int tail);
      int            n_acc, d, mism;
      logic [NB-1:0] full, exp_res;
      logic          exp_err;
      beginRun(word, bad, ab_acc, re_at);
      applyStimulus();
      checkOutput("clearOnStart", 64'({busy, result}), 64'({1'b1, {NB{1'b0}}}));
      while (finish_cyc < 0 && cyc < 400) applyStimulus();
      for (int i = 0; i < tail; i++) applyStimulus();

      n_acc = (ab_acc >= 0 && ab_acc < NACC) ? ab_acc + 1 : NACC;
      d     = n_acc - SR - KL;
      if (d < 0) d = 0;
      full = word;
      if (bad >= 0) full[NB-1-bad] = 1'b0;
      exp_res = (d == 0) ? '0 : (full >> (NB - d));
      exp_err = (ab_acc >= 0 && ab_acc < NACC) || (bad >= 0 && bad < d);

      checkOutput("finishCycle", 64'(finish_cyc), 64'(3 * n_acc + 1));
      checkOutput("donePulse", 64'({fin_done, fin_err}), 64'({!exp_err, exp_err}));
      checkOutput("result", 64'(fin_result), 64'(exp_res));
      checkOutput("accessCount", 64'(got_addr.size()), 64'(n_acc));
      mism = 0;
      for (int k = 0; k < got_addr.size() && k < n_acc; k++)
         if (got_addr[k] !== model_addr(k)) mism++;
      checkOutput("addrSeq", 64'(mism), 64'(0));
      checkOutput("busTiming", 64'(viol), 64'(0));
      checkOutput("pulseCount", 64'(done_count), 64'(1));
   endtask

   task automatic runReset();
      beginRun(16'h5A5A, -1, -1, -1);
      while (strobe_count < SR + KL + 9 && cyc < 400) applyStimulus();
      rst = 1'b1;
      @(negedge clk);
      checkReset("midReset");
      rst = 1'b0;
      @(negedge clk);
      checkReset("idleAfterReset");
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] simulation did not terminate");
   end

   initial begin
      logic [13:0] plan_ba [7];
      logic [NB-1:0] w;
      int bad, ab;
      plan_ba = '{14'h1000, 14'h1000, 14'h1090, 14'h10A0, 14'h1050, 14'h10B0, 14'h1020};

      rst = 1'b1; start = 1'b0; abort = 1'b0; sdrd = 1'b0; sdrd_valid = 1'b1;
      resp_bad = -1; abort_acc = -1; restart_at = -1; finish_cyc = -1;
      repeat (3) @(negedge clk);
      checkReset("resetState");
      rst   = 1'b0;
      abort = 1'b1;
      repeat (3) @(negedge clk);
      checkReset("abortInIdle");
      abort = 1'b0;

      $display("[TB] clean read of C35A");
      runSeq(16'hC35A, -1, -1, -1, 0);
      for (int k = 0; k < 7; k++) checkOutput($sformatf("planBa%0d", k), 64'(got_addr[k]), 64'(plan_ba[k]));
      checkOutput("planResult", 64'(fin_result), 64'(16'hC35A));

      $display("[TB] back-to-back start with a restart pulse while busy");
      runSeq(16'h1234, -1, -1, 20, 3);

      $display("[TB] sdrd_valid dropped on data bit 5");
      runSeq(16'hFFFF, 5, -1, -1, 2);
      checkOutput("planBadBit", 64'(fin_result), 64'(16'hFBFF));

      $display("[TB] abort during second key access");
      runSeq(16'($urandom), -1, SR + 1, -1, 6);
      checkOutput("planAbortResult", 64'(fin_result), 64'(0));

      $display("[TB] start and abort together");
      runSeq(16'($urandom), -1, 0, -1, 3);

      $display("[TB] reset during data bit 8");
      runReset();
      runSeq(16'hA5C3, -1, -1, -1, 2);

      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++) begin
         w   = 16'($urandom);
         bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NACC - 1)) : -1;
         runSeq(w, bad, ab, -1, 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
